// File: rtl/contador_pulsos.sv
// rtl/contador_pulsos.sv - glitch-filtered pulse detector with windowed event counter
module contador_pulsos #(
   parameter int W         = 8,
   parameter int MIN_WIDTH = 3,
   parameter int WINDOW    = 1000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic         datain,
   output logic         pulse,
   output logic         level,
   output logic [W-1:0] count,
   output logic         count_valid,
   output logic         overflow
);

   localparam int SW = $clog2(MIN_WIDTH + 1);
   localparam int WW = $clog2(WINDOW);
   localparam logic [SW-1:0] STAB_LAST = SW'(MIN_WIDTH - 1);
   localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);

   typedef enum logic [1:0] {LOW, RISE_CHK, HIGH, FALL_CHK} state_t;

   state_t        state;
   logic [SW-1:0] stab;
   logic [WW-1:0] wcnt;
   logic [W-1:0]  run;
   logic          run_ovf;

   logic          rise;
   logic          fall;
   logic          sat;
   logic [W-1:0]  run_next;
   logic          ovf_next;

   // A change is accepted on the sample that completes MIN_WIDTH consecutive samples at the new level.
   assign rise = enable && datain &&
                 ((state == LOW && MIN_WIDTH == 1) || (state == RISE_CHK && stab == STAB_LAST));
   assign fall = enable && !datain &&
                 ((state == HIGH && MIN_WIDTH == 1) || (state == FALL_CHK && stab == STAB_LAST));

   assign sat      = &run;
   assign run_next = (rise && !sat) ? run + 1'b1 : run;
   assign ovf_next = run_ovf | (rise & sat);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= LOW;
         stab        <= '0;
         wcnt        <= '0;
         run         <= '0;
         run_ovf     <= 1'b0;
         pulse       <= 1'b0;
         level       <= 1'b0;
         count       <= '0;
         count_valid <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         pulse       <= 1'b0;
         count_valid <= 1'b0;
         if (enable) begin
            case (state)
               LOW: begin
                  if (rise) begin
                     state <= HIGH;
                     level <= 1'b1;
                  end else if (datain) begin
                     state <= RISE_CHK;
                     stab  <= SW'(1);
                  end
               end
               RISE_CHK: begin
                  if (!datain) begin
                     state <= LOW;
                     stab  <= '0;
                  end else if (rise) begin
                     state <= HIGH;
                     stab  <= '0;
                     level <= 1'b1;
                  end else begin
                     stab <= stab + 1'b1;
                  end
               end
               HIGH: begin
                  if (fall) begin
                     state <= LOW;
                     level <= 1'b0;
                  end else if (!datain) begin
                     state <= FALL_CHK;
                     stab  <= SW'(1);
                  end
               end
               FALL_CHK: begin
                  if (datain) begin
                     state <= HIGH;
                     stab  <= '0;
                  end else if (fall) begin
                     state <= LOW;
                     stab  <= '0;
                     level <= 1'b0;
                  end else begin
                     stab <= stab + 1'b1;
                  end
               end
               default: state <= LOW;
            endcase

            pulse <= rise;

            // The closing cycle publishes the count including an event accepted on that same edge.
            if (wcnt == WIN_LAST) begin
               count       <= run_next;
               overflow    <= ovf_next;
               count_valid <= 1'b1;
               run         <= '0;
               run_ovf     <= 1'b0;
               wcnt        <= '0;
            end else begin
               run     <= run_next;
               run_ovf <= ovf_next;
               wcnt    <= wcnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_contador_pulsos.sv
// tb/tb_contador_pulsos.sv - self-checking bench for contador_pulsos
module tb_contador_pulsos;

   localparam int WIN = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, enable, datain;
   logic       p0, l0, cv0, o0;
   logic [2:0] c0;
   logic       p1, l1, cv1, o1;
   logic [7:0] c1;

   contador_pulsos #(.W(3), .MIN_WIDTH(3), .WINDOW(WIN)) dut0 (
      .clk(clk), .rst(rst), .enable(enable), .datain(datain),
      .pulse(p0), .level(l0), .count(c0), .count_valid(cv0), .overflow(o0));

   contador_pulsos #(.W(8), .MIN_WIDTH(1), .WINDOW(WIN)) dut1 (
      .clk(clk), .rst(rst), .enable(enable), .datain(datain),
      .pulse(p1), .level(l1), .count(c1), .count_valid(cv1), .overflow(o1));

   typedef struct {
      bit lvl; int run; int wc; int cnt; bit ovf; int count; bit ovf_o; bit p; bit cv;
   } mstate_t;

   typedef struct { bit [11:0] e0; bit [11:0] e1; } sb_t;

   typedef struct { bit r; bit e; bit d; bit p; bit l; } vec_t;

   vec_t tbl [30] = '{
      '{1,1,1,0,0}, '{1,1,1,0,0}, '{1,1,1,0,0},
      '{0,1,1,0,0}, '{0,1,1,0,0}, '{0,1,1,1,1}, '{0,1,1,0,1},
      '{0,1,0,0,1}, '{0,1,0,0,1}, '{0,1,0,0,0},
      '{0,1,1,0,0}, '{0,1,1,0,0}, '{0,1,0,0,0}, '{0,1,0,0,0},
      '{0,1,1,0,0}, '{0,1,1,0,0}, '{0,1,1,1,1}, '{0,1,1,0,1}, '{0,1,1,0,1},
      '{0,1,0,0,1}, '{0,1,0,0,1}, '{0,1,0,0,0},
      '{0,1,1,0,0}, '{0,1,1,0,0}, '{0,1,1,1,1},
      '{0,1,0,0,1}, '{0,1,1,0,1}, '{0,1,0,0,1}, '{0,1,0,0,1}, '{0,1,0,0,0}
   };

   mstate_t m0, m1;
   sb_t     sbq [$];
   int      n_chk = 0, n_fail = 0;
   int      cyc = 0, cyc0 = 0, cv_cnt = 0, cv_cyc = 0, cv_first = 0;
   int      last_count = 0;
   bit      last_ovf = 0;

   function automatic mstate_t mstep(mstate_t s, bit r, bit e, bit d, int minw, int maxc);
      mstate_t n;
      n = s;
      n.p = 0;
      n.cv = 0;
      if (r) begin
         n = '{default: 0};
         return n;
      end
      if (!e) return n;
      if (d != s.lvl) begin
         n.run = s.run + 1;
         if (n.run == minw) begin
            n.lvl = d;
            n.run = 0;
            n.p = d;
         end
      end else begin
         n.run = 0;
      end
      if (n.p) begin
         if (s.cnt == maxc) n.ovf = 1;
         else n.cnt = s.cnt + 1;
      end
      n.wc = s.wc + 1;
      if (n.wc == WIN) begin
         n.cv = 1;
         n.count = n.cnt;
         n.ovf_o = n.ovf;
         n.cnt = 0;
         n.ovf = 0;
         n.wc = 0;
      end
      return n;
   endfunction

   function automatic bit [11:0] pk(mstate_t s);
      return {s.p, s.lvl, s.cv, s.ovf_o, 8'(s.count)};
   endfunction

   task automatic check(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(bit r, bit e, bit d);
      sb_t x;
      rst = r;
      enable = e;
      datain = d;
      m0 = mstep(m0, r, e, d, 3, 7);
      m1 = mstep(m1, r, e, d, 1, 255);
      sbq.push_back('{pk(m0), pk(m1)});
      @(posedge clk);
      #1;
      cyc++;
      x = sbq.pop_front();
      check("dut0 {pulse,level,cv,ovf,count}", int'({p0, l0, cv0, o0, 8'(c0)}), int'(x.e0));
      check("dut1 {pulse,level,cv,ovf,count}", int'({p1, l1, cv1, o1, c1}), int'(x.e1));
      if (cv0) begin
         cv_cnt++;
         cv_cyc = cyc;
         last_count = int'(c0);
         last_ovf = o0;
      end
   endtask

   task automatic run(bit d, int n);
      for (int i = 0; i < n; i++) step(0, 1, d);
   endtask

   task automatic pulses(int n, int hi, int lo);
      for (int i = 0; i < n; i++) begin
         run(1, hi);
         run(0, lo);
      end
   endtask

   initial begin
      m0 = '{default: 0};
      m1 = '{default: 0};

      // reset, glitch rejection and debounce latency, against hand-derived vectors
      for (int i = 0; i < 30; i++) begin
         step(tbl[i].r, tbl[i].e, tbl[i].d);
         check($sformatf("vec%0d pulse", i), int'(p0), int'(tbl[i].p));
         check($sformatf("vec%0d level", i), int'(l0), int'(tbl[i].l));
         if (tbl[i].r) check($sformatf("vec%0d count/cv/ovf", i), int'({c0, cv0, o0}), 0);
      end

      // four clean pulses in one window, then an empty window
      step(1, 1, 0);
      cyc0 = cyc;
      cv_cnt = 0;
      pulses(4, 5, 5);
      run(0, 60);
      check("win cv count", cv_cnt, 1);
      check("win cv period", cv_cyc - cyc0, WIN);
      check("win count", last_count, 4);
      check("win ovf", int'(last_ovf), 0);
      run(0, 100);
      check("empty cv count", cv_cnt, 2);
      check("empty count", last_count, 0);

      // saturation at 7 with overflow, cleared by the next window
      step(1, 1, 0);
      cv_cnt = 0;
      pulses(10, 3, 3);
      run(0, 40);
      check("sat cv count", cv_cnt, 1);
      check("sat count", last_count, 7);
      check("sat ovf", int'(last_ovf), 1);
      run(0, 100);
      check("post-sat count", last_count, 0);
      check("post-sat ovf", int'(last_ovf), 0);

      // event accepted on the window's closing cycle, then enable gap mid-check
      step(1, 1, 0);
      cv_cnt = 0;
      run(0, 97);
      run(1, 3);
      check("edge pulse", int'(p0), 1);
      check("edge cv", int'(cv0), 1);
      check("edge count", int'(c0), 1);
      cv_first = cyc;
      run(0, 3);
      run(1, 2);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1'($urandom_range(0, 1)));
         check("disabled pulse", int'(p0), 0);
      end
      step(0, 1, 1);
      check("resume pulse", int'(p0), 1);
      for (int i = 0; i < 200 && cv_cnt < 2; i++) step(0, 1, 0);
      check("delayed cv seen", cv_cnt, 2);
      check("delayed cv period", cv_cyc - cv_first, WIN + 10);
      check("delayed count", last_count, 1);

      // reset mid-window discards the partial window
      step(1, 1, 0);
      cv_cnt = 0;
      pulses(2, 5, 5);
      run(0, 30);
      step(1, 1, 1);
      cyc0 = cyc;
      check("mid-rst no cv", cv_cnt, 0);
      pulses(1, 5, 5);
      run(0, 90);
      check("post-rst cv count", cv_cnt, 1);
      check("post-rst period", cv_cyc - cyc0, WIN);
      check("post-rst count", last_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
